// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (LS).
// Build option: define ARB_RR_EN for round-robin tie breaking (default is fixed LS > IF).
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winner's command
// REQ    | mem_req held with a stable command until mem_gnt
// WAIT   | command accepted; waiting for mem_rvalid to route back to the owner
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                state_q;
  logic                  owner_q;   // 1 = LS, 0 = IF
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [DATA_W/8-1:0]   mem_be_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic                  busy_q;
  logic                  pick_ls;
  logic                  gnt_hit;
  logic                  rsp_hit;

  assign gnt_hit = (state_q == S_REQ)  && mem_gnt;
  assign rsp_hit = (state_q == S_WAIT) && mem_rvalid;

`ifdef ARB_RR_EN
  logic last_owner_q;

  // On a tie the requester not served last wins; reset value LS hands the first tie to IF.
  always_comb begin
    pick_ls = ls_req;
    if (ls_req && if_req) pick_ls = ~last_owner_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       last_owner_q <= 1'b1;
    else if (gnt_hit) last_owner_q <= owner_q;
  end
`else
  assign pick_ls = ls_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (if_req || ls_req) begin
            owner_q     <= pick_ls;
            mem_we_q    <= pick_ls ? ls_we : 1'b0;
            mem_be_q    <= pick_ls ? ls_be : '1;
            mem_addr_q  <= pick_ls ? ls_addr : if_addr;
            mem_wdata_q <= pick_ls ? ls_wdata : '0;
            mem_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

  // Handshake pulses follow the memory combinationally, steered only to the owner.
  assign if_gnt    = gnt_hit && !owner_q;
  assign ls_gnt    = gnt_hit &&  owner_q;
  assign if_rvalid = rsp_hit && !owner_q;
  assign ls_rvalid = rsp_hit &&  owner_q;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; expectations follow ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [3:0]  ls_be;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
  logic [31:0] if_rdata, ls_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ls;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        fly_q[$];
  logic [31:0] rd_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_gnt = 0, n_rsp = 0, gnt_cyc = 0, rsp_cyc = 0;
  int gnt_dly = 0, rv_dly = 0;
  int spur_req = 0, spur_done = 0;
  logic [31:0] spur_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event (cycle %0d)", name, cyc);
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_cmd"}, {mem_addr, mem_wdata}, 64'd0);
    chk({tag, "_ctl"}, {mem_req, mem_we, mem_be, busy, if_gnt, if_rvalid, ls_gnt, ls_rvalid}, 64'd0);
    chk({tag, "_rdata"}, {if_rdata, ls_rdata}, 64'd0);
  endtask

  // Memory model: grants after gnt_dly cycles of mem_req, answers rv_dly cycles after that.
  initial begin : responder
    int r, cnt;
    r = 0; cnt = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (!reset) r = 0;
      else if (spur_req != spur_done) begin
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = spur_data;
        spur_done = spur_req;
      end else begin
        if (r == 0 && mem_req) begin r = 1; cnt = gnt_dly; end
        else if (r == 2) begin
          if (cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'd0;
            r = 0;
          end else cnt--;
        end
        if (r == 1) begin
          if (cnt == 0) begin mem_gnt = 1'b1; r = 2; cnt = rv_dly; end
          else cnt--;
        end
      end
    end
  end

  // Monitor: compares the presented command, grants and responses against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      chk("idle_rdata_zero", {(!if_rvalid && if_rdata != 0), (!ls_rvalid && ls_rdata != 0)}, 64'd0);
      if (mem_req) begin
        if (exp_q.size() == 0) fail_now("unexpected_mem_req");
        else begin
          chk("cmd_we_be_addr", {mem_we, mem_be, mem_addr}, {exp_q[0].we, exp_q[0].be, exp_q[0].addr});
          if (exp_q[0].ls) chk("cmd_wdata", mem_wdata, exp_q[0].wdata);
        end
      end
      if (if_gnt || ls_gnt) begin
        if (exp_q.size() == 0) fail_now("unexpected_gnt");
        else begin
          txn_t t;
          t = exp_q.pop_front();
          chk("gnt_owner", {ls_gnt, if_gnt}, {t.ls, !t.ls});
          fly_q.push_back(t);
        end
        n_gnt++;
        gnt_cyc = cyc;
      end
      if (if_rvalid || ls_rvalid) begin
        if (fly_q.size() == 0) fail_now("unexpected_rvalid");
        else begin
          txn_t t;
          t = fly_q.pop_front();
          chk("rsp_owner", {ls_rvalid, if_rvalid}, {t.ls, !t.ls});
          chk("rsp_rdata", t.ls ? ls_rdata : if_rdata, t.rdata);
        end
        n_rsp++;
        rsp_cyc = cyc;
      end
    end
  end

  task automatic push_exp(input bit ls, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
    txn_t t;
    t.ls = ls; t.we = ls ? we : 1'b0; t.be = ls ? be : 4'hF;
    t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    exp_q.push_back(t);
    rd_q.push_back(rdata);
  endtask

  // One lone transaction; gl/rl are the expected grant/response cycle offsets (0 = unchecked).
  task automatic do_txn(input bit ls, input bit we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int gd, input int rd,
                        input bit drop_early, input int gl, input int rl);
    int t0, g0, r0, w;
    gnt_dly = gd; rv_dly = rd;
    @(posedge clk); #1;
    push_exp(ls, we, be, addr, wdata, rdata);
    if (ls) begin ls_req = 1'b1; ls_we = we; ls_be = be; ls_addr = addr; ls_wdata = wdata; end
    else begin if_req = 1'b1; if_addr = addr; end
    t0 = cyc; g0 = n_gnt; r0 = n_rsp;
    if (drop_early) begin @(posedge clk); #1; if_req = 1'b0; ls_req = 1'b0; end
    w = 0;
    while (n_gnt == g0 && w < 100) begin @(negedge clk); #1; w++; end
    if (n_gnt == g0) begin fail_now("gnt_wait"); return; end
    if (gl > 0) chk("gnt_latency", gnt_cyc - t0, gl);
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;
    w = 0;
    while (n_rsp == r0 && w < 100) begin @(negedge clk); #1; w++; end
    if (n_rsp == r0) begin fail_now("rsp_wait"); return; end
    if (rl > 0) chk("rsp_latency", rsp_cyc - t0, rl);
    chk("busy_in_rsp_cycle", busy, 1);
    @(posedge clk); #1;
    chk("busy_after_rsp", busy, 0);
    chk("gnt_count", n_gnt - g0, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin : stim
    int g0, r0, w;
    reset = 1'b0;
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_check("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    rst_check("post_reset");

    // Lone fetch at minimum latency.
    do_txn(0, 0, 4'h0, 32'h100, 32'h0, 32'h00500093, 0, 0, 0, 1, 2);
    // Store: write ack routed to LS only.
    do_txn(1, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 32'h0, 0, 0, 0, 1, 2);
    // Load with small gnt and response delays.
    do_txn(1, 0, 4'hF, 32'h3000, 32'h0, 32'hCAFE0001, 1, 1, 0, 2, 4);
    // Memory stall: gnt low 5 cycles, response 3 cycles after gnt.
    do_txn(0, 0, 4'h0, 32'h140, 32'h0, 32'h13579BDF, 5, 2, 0, 6, 9);
    // Requester drops req before gnt; transaction still completes.
    do_txn(1, 0, 4'hC, 32'h3FF8, 32'h0, 32'hA5A5F00D, 3, 0, 1, 4, 5);

    // Spurious mem_gnt / mem_rvalid while idle.
    @(negedge clk);
    spur_data = 32'h1234;
    spur_req++;
    g0 = n_gnt; r0 = n_rsp;
    repeat (3) @(negedge clk);
    chk("spur_busy_req", {busy, mem_req}, 64'd0);
    chk("spur_no_events", {n_gnt - g0, n_rsp - r0}, 64'd0);

    // Tie with both requests held for four transactions; reset restores last_owner.
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    gnt_dly = 0; rv_dly = 0;
    @(posedge clk); #1;
`ifdef ARB_RR_EN
    push_exp(0, 0, 4'h0, 32'h300, 32'h0, 32'h11110000);
    push_exp(1, 1, 4'h5, 32'h4000, 32'h87654321, 32'h22220000);
    push_exp(0, 0, 4'h0, 32'h300, 32'h0, 32'h33330000);
    push_exp(1, 1, 4'h5, 32'h4000, 32'h87654321, 32'h44440000);
`else
    push_exp(1, 1, 4'h5, 32'h4000, 32'h87654321, 32'h11110000);
    push_exp(1, 1, 4'h5, 32'h4000, 32'h87654321, 32'h22220000);
    push_exp(1, 1, 4'h5, 32'h4000, 32'h87654321, 32'h33330000);
    push_exp(1, 1, 4'h5, 32'h4000, 32'h87654321, 32'h44440000);
`endif
    g0 = n_gnt; r0 = n_rsp;
    if_req = 1'b1; if_addr = 32'h300;
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'h5; ls_addr = 32'h4000; ls_wdata = 32'h87654321;
    w = 0;
    while (n_gnt - g0 < 4 && w < 100) begin @(negedge clk); #1; w++; end
    if (n_gnt - g0 < 4) fail_now("tie_gnt_wait");
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;
    w = 0;
    while (n_rsp - r0 < 4 && w < 100) begin @(negedge clk); #1; w++; end
    if (n_rsp - r0 < 4) fail_now("tie_rsp_wait");
    chk("tie_all_served", exp_q.size(), 0);

    // Reset while waiting for the response.
    gnt_dly = 0; rv_dly = 5;
    @(posedge clk); #1;
    push_exp(0, 0, 4'h0, 32'h500, 32'h0, 32'hBAD0BAD0);
    if_req = 1'b1; if_addr = 32'h500;
    g0 = n_gnt; w = 0;
    while (n_gnt == g0 && w < 100) begin @(negedge clk); #1; w++; end
    if (n_gnt == g0) fail_now("rst_gnt_wait");
    @(posedge clk); #1;
    if_req = 1'b0;
    @(posedge clk); #1;
    chk("wait_state_busy", busy, 1);
    reset = 1'b0;
    #1;
    rst_check("mid_reset");
    exp_q.delete(); fly_q.delete(); rd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    do_txn(0, 0, 4'h0, 32'h600, 32'h0, 32'h0BADF00D, 0, 0, 0, 1, 2);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
